// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential fetches over a req/ack memory port,
// buffers returned words in a show-ahead FIFO and hands {instruction, PC} to the cpu.
module fetch_unit #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memAck,
    input  logic [INSTR_W-1:0] memData,
    output logic               instrValid,
    input  logic               instrReady,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instrPC,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectTarget
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    entry_t            fifo_mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt, count_after;
    logic [ADDR_W-1:0] fetch_pc;
    state_t            state, state_nxt;
    logic              push, pop, issue;

    assign instrValid  = (count != '0);
    assign pop         = instrValid && instrReady && !redirect;
    // Occupancy if the word being acked this cycle is pushed.
    assign count_after = count + CNT_W'(1) - CNT_W'(pop);
    assign count_nxt   = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);

    assign head        = fifo_mem[rd_ptr];
    assign instruction = instrValid ? head.word : '0;
    assign instrPC     = instrValid ? head.pc   : '0;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && count < FULL) begin
                    state_nxt = BUSY;
                    issue     = 1'b1;
                end
            end
            BUSY: begin
                if (memAck) begin
                    if (redirect) begin
                        state_nxt = IDLE;
                    end else begin
                        push = 1'b1;
                        if (count_after < FULL) issue = 1'b1;
                        else                    state_nxt = IDLE;
                    end
                end else if (redirect) begin
                    // Request already on the bus must complete; its data is dropped.
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (memAck) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memAddr  <= '0;
            fetch_pc <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state  <= state_nxt;
            memReq <= (state_nxt != IDLE);
            count  <= count_nxt;
            if (issue) memAddr <= fetch_pc;
            if (redirect)   fetch_pc <= redirectTarget;
            else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(push);
                rd_ptr <= rd_ptr + PTR_W'(pop);
            end
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= '{word: memData, pc: memAddr};
    end

endmodule
